qbert_test2_irq_capture: RTL and testbench

QBERT_TEST2_IRQ_CAPTURE -- requirements
Module: qbert_test2_irq_capture

---
 rtl/qbert_test2_irq_capture.sv | 120 ++++++++++++
 tb/tb_qbert_test2_irq_capture.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_test2_irq_capture.sv
`default_nettype none
// ============================================================================
//  Module   : qbert_test2_irq_capture
//  Purpose  : Edge-capturing interrupt controller on an Avalon-MM slave port.
//             Rising edges on irq_in latch PENDING, repeat edges latch
//             OVERFLOW, MASK gates the aggregated irq output, and
//             EVENT_COUNT counts the cycles that saw any edge.
//  Revision : 1.0  initial release
// ============================================================================
module qbert_test2_irq_capture #(
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [7:0]  irq_in,
    output logic        irq
);

    localparam logic [2:0]  c_ADDR_PENDING  = 3'd0;
    localparam logic [2:0]  c_ADDR_MASK     = 3'd1;
    localparam logic [2:0]  c_ADDR_OVERFLOW = 3'd2;
    localparam logic [2:0]  c_ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0]  c_ADDR_RAW      = 3'd4;
    localparam logic [2:0]  c_ADDR_COUNT    = 3'd5;
    localparam logic [15:0] c_COUNT_MAX     = 16'hFFFF;

    logic [7:0]  prev_q,     prev_d;
    logic [7:0]  pending_q,  pending_d;
    logic [7:0]  mask_q,     mask_d;
    logic [7:0]  overflow_q, overflow_d;
    logic [15:0] count_q,    count_d;
    logic [15:0] readdata_q, readdata_d;

    logic        wr_en;
    logic [7:0]  edge_vec;
    logic [7:0]  pend_clr;
    logic [7:0]  ovf_clr;
    logic [7:0]  masked;
    logic [2:0]  active_idx;
    logic        active_vld;

    // Decode the write strobe, per-bit edges and W1C clear vectors
    always_comb begin
        wr_en    = chipselect & ~write_n;
        edge_vec = irq_in & ~prev_q;
        pend_clr = (wr_en && address == c_ADDR_PENDING)  ? writedata[7:0] : 8'h00;
        ovf_clr  = (wr_en && address == c_ADDR_OVERFLOW) ? writedata[7:0] : 8'h00;
    end

    // Lowest-numbered pending and enabled source; index forced to 0 when idle
    always_comb begin
        masked     = pending_q & mask_q;
        active_vld = |masked;
        active_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) begin
                active_idx = i[2:0];
            end
        end
    end

    // Next-state for capture, overflow, mask and the saturating event counter
    always_comb begin
        prev_d     = irq_in;
        // A new edge always wins over a coincident clear
        pending_d  = (pending_q & ~pend_clr) | edge_vec;
        // Overflow only when the earlier event is still unacknowledged
        overflow_d = (overflow_q & ~ovf_clr) | (edge_vec & pending_q & ~pend_clr);
        mask_d     = (wr_en && address == c_ADDR_MASK) ? writedata[7:0] : mask_q;
        count_d    = count_q;
        if (wr_en && address == c_ADDR_COUNT) begin
            count_d = (|edge_vec) ? 16'd1 : 16'd0;
        end else if ((|edge_vec) && count_q != c_COUNT_MAX) begin
            count_d = count_q + 16'd1;
        end
    end

    // Read mux, sampled every cycle regardless of chipselect
    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            c_ADDR_PENDING:  readdata_d = {8'h00, pending_q};
            c_ADDR_MASK:     readdata_d = {8'h00, mask_q};
            c_ADDR_OVERFLOW: readdata_d = {8'h00, overflow_q};
            c_ADDR_ACTIVE:   readdata_d = {12'h000, active_vld, active_idx};
            c_ADDR_RAW:      readdata_d = {8'h00, irq_in};
            c_ADDR_COUNT:    readdata_d = count_q;
            default:         readdata_d = 16'h0000;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= 8'h00;
            pending_q  <= 8'h00;
            mask_q     <= RESET_MASK;
            overflow_q <= 8'h00;
            count_q    <= 16'h0000;
            readdata_q <= 16'h0000;
        end else begin
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = active_vld;

endmodule
`default_nettype wire

// File: tb/tb_qbert_test2_irq_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qbert_test2_irq_capture
//  Purpose  : Randomized and directed bench for qbert_test2_irq_capture with a
//             behavioural reference model and a queue-based read scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qbert_test2_irq_capture;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    int n_pass;
    int n_total;

    typedef struct {
        logic [15:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic rd_vld;

    // Reference model state
    logic [7:0] m_pending;
    logic [7:0] m_mask;
    logic [7:0] m_ovf;
    logic [7:0] m_prev;
    int         m_count;

    qbert_test2_irq_capture #(.RESET_MASK(8'h00)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired: sim_time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_pending = 8'h00;
        m_mask    = 8'h00;
        m_ovf     = 8'h00;
        m_prev    = 8'h00;
        m_count   = 0;
    endtask

    function automatic logic model_irq();
        return (m_pending & m_mask) != 8'h00;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a, input logic [7:0] raw);
        logic [15:0] r;
        r = 16'h0000;
        case (a)
            3'd0: r = {8'h00, m_pending};
            3'd1: r = {8'h00, m_mask};
            3'd2: r = {8'h00, m_ovf};
            3'd3: begin
                for (int i = 0; i < 8; i++) begin
                    if (m_pending[i] && m_mask[i]) begin
                        r = 16'h0008 + 16'(i);
                        break;
                    end
                end
            end
            3'd4: r = {8'h00, raw};
            3'd5: r = 16'(m_count);
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic model_step(input logic cs, input logic [2:0] a, input logic wn,
                              input logic [15:0] wd, input logic [7:0] in);
        bit we, any_edge, e, clr_p, clr_o;
        logic [7:0] np, no;
        we = cs && !wn;
        any_edge = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e     = in[i] && !m_prev[i];
            clr_p = we && a == 3'd0 && wd[i];
            clr_o = we && a == 3'd2 && wd[i];
            any_edge = any_edge | e;
            if (e) np[i] = 1'b1;
            else if (clr_p) np[i] = 1'b0;
            else np[i] = m_pending[i];
            if (e && m_pending[i] && !clr_p) no[i] = 1'b1;
            else if (clr_o) no[i] = 1'b0;
            else no[i] = m_ovf[i];
        end
        if (we && a == 3'd5) m_count = any_edge ? 1 : 0;
        else if (any_edge && m_count < 65535) m_count = m_count + 1;
        if (we && a == 3'd1) m_mask = wd[7:0];
        m_pending = np;
        m_ovf     = no;
        m_prev    = in;
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; leaves the bench just after the next one.
    task automatic cycle(input logic cs, input logic [2:0] a, input logic wn,
                         input logic [15:0] wd, input logic [7:0] in, input string name);
        exp_t ex;
        chipselect = cs;
        address    = a;
        write_n    = wn;
        writedata  = wd;
        irq_in     = in;
        ex.rd   = model_read(a, in);
        ex.name = name;
        model_step(cs, a, wn, wd, in);
        ex.irq  = model_irq();
        if (cs && wn) sb_q.push_back(ex);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] wd, input logic [7:0] in);
        cycle(1'b1, a, 1'b0, wd, in, "wr");
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] in, input string name);
        cycle(1'b1, a, 1'b1, 16'h0000, in, name);
    endtask

    task automatic idle(input logic [7:0] in);
        cycle(1'b0, 3'd0, 1'b1, 16'h0000, in, "idle");
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_vld <= 1'b0;
        else rd_vld <= chipselect && write_n;
    end

    always @(negedge clk) begin
        exp_t ex;
        if (rd_vld) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: actual=read_seen required=queued_expectation");
            end else begin
                ex = sb_q.pop_front();
                check({"rd_", ex.name}, readdata, ex.rd);
                check({"irq_", ex.name}, {15'd0, irq}, {15'd0, ex.irq});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] tog;
        n_pass = 0;
        n_total = 0;
        chipselect = 1'b0;
        address = 3'd0;
        write_n = 1'b1;
        writedata = 16'h0000;
        irq_in = 8'h00;
        reset_n = 1'b0;
        model_reset();
        #23;
        check("reset_readdata", readdata, 16'h0000);
        check("reset_irq", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        rd(3'd1, 8'h00, "reset_mask");
        rd(3'd5, 8'h00, "reset_count");

        // Single pulse on bit 0 with MASK=01
        wr(3'd1, 16'h0001, 8'h00);
        idle(8'h01);
        rd(3'd0, 8'h00, "pulse_pending");
        rd(3'd3, 8'h00, "pulse_active");
        rd(3'd5, 8'h00, "pulse_count");

        // Simultaneous edges on bits 5 and 2
        wr(3'd0, 16'h00FF, 8'h00);
        wr(3'd5, 16'h0000, 8'h00);
        wr(3'd1, 16'h00FF, 8'h00);
        idle(8'h24);
        rd(3'd0, 8'h00, "dual_pending");
        rd(3'd3, 8'h00, "dual_active");
        rd(3'd5, 8'h00, "dual_count");

        // Overflow on bit 3, then W1C
        idle(8'h08);
        idle(8'h00);
        idle(8'h08);
        idle(8'h00);
        rd(3'd2, 8'h00, "ovf_set");
        wr(3'd2, 16'h0008, 8'h00);
        rd(3'd2, 8'h00, "ovf_clr");

        // Clear of bit 1 colliding with a new edge on bit 1
        idle(8'h02);
        idle(8'h00);
        wr(3'd0, 16'h0002, 8'h02);
        rd(3'd0, 8'h02, "w1c_race_pending");
        rd(3'd2, 8'h02, "w1c_race_ovf");
        rd(3'd4, 8'h02, "raw");
        rd(3'd6, 8'h02, "addr6");
        rd(3'd7, 8'h00, "addr7");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] a;
            logic cs, wn;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) != 0);
            cycle(cs, a, wn, 16'($urandom), 8'($urandom), "rand");
        end

        // Counter saturation: one edge every cycle by alternating two sources
        idle(8'h00);
        wr(3'd5, 16'h0000, 8'h00);
        tog = 8'h01;
        for (int n = 0; n < 65535; n++) begin
            idle(tog);
            tog = (tog == 8'h01) ? 8'h02 : 8'h01;
        end
        rd(3'd5, 8'h02, "count_full");
        idle(tog);
        rd(3'd5, tog, "count_sat");
        wr(3'd5, 16'h0000, tog);
        rd(3'd5, tog, "count_clr");

        // Mid-operation asynchronous reset, released with all inputs high
        idle(8'h00);
        idle(8'h10);
        idle(8'h00);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_readdata", readdata, 16'h0000);
        check("async_rst_irq", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        irq_in = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        idle(8'hFF);
        rd(3'd0, 8'hFF, "rel_pending");
        rd(3'd5, 8'hFF, "rel_count");
        rd(3'd1, 8'hFF, "rel_mask");
        idle(8'hFF);
        idle(8'hFF);
        rd(3'd5, 8'hFF, "held_count");
        rd(3'd2, 8'hFF, "held_ovf");

        idle(8'h00);
        idle(8'h00);
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: actual=%0d required=0 outstanding reads", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
